// File: rtl/pipeline_mem_responder_if.sv
// Memory port between the pipeline datapath (master) and the memory responder (slave).
interface pipeline_mem_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         busy;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_resp, mem_rdata, busy
  );
endinterface

// File: rtl/pipeline_mem_responder.sv
// Fixed-latency memory responder: one request at a time, 16-bit word reads,
// whole 128-bit line writes committed on the edge that leaves RESP.
module pipeline_mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_mem_responder_if.slave     bus
);

  localparam int unsigned AW = $clog2(LINES);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic            op_write;
  logic [AW-1:0]   line_q;
  logic [2:0]      word_q;
  logic [127:0]    wdata_q;
  logic [127:0]    mem [LINES];

  logic            req_any;
  logic            req_dropped;
  logic [AW-1:0]   line_sel;
  logic [2:0]      word_sel;
  logic [15:0]     word_rd;
  logic            unused_addr;

  assign req_any     = bus.mem_read | bus.mem_write;
  assign req_dropped = op_write ? !bus.mem_write : !bus.mem_read;

  // With LATENCY=1 the response leaves IDLE directly, so select from the live address
  assign line_sel = (state == IDLE) ? bus.mem_address[4+AW-1:4] : line_q;
  assign word_sel = (state == IDLE) ? bus.mem_address[3:1]      : word_q;
  assign word_rd  = mem[line_sel][{word_sel, 4'b0000} +: 16];

  // Bit 0 and bits above the line index are intentionally ignored
  assign unused_addr = ^bus.mem_address;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= '0;
      op_write      <= 1'b0;
      line_q        <= '0;
      word_q        <= '0;
      wdata_q       <= '0;
      bus.mem_resp  <= 1'b0;
      bus.mem_rdata <= 16'h0000;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            op_write <= bus.mem_write;
            line_q   <= bus.mem_address[4+AW-1:4];
            word_q   <= bus.mem_address[3:1];
            wdata_q  <= bus.mem_wdata;
            bus.busy <= 1'b1;
            if (LATENCY == 1) begin
              state         <= RESP;
              counter       <= '0;
              bus.mem_resp  <= 1'b1;
              bus.mem_rdata <= word_rd;
            end else begin
              state   <= WAIT;
              counter <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (req_dropped) begin
            state    <= IDLE;
            counter  <= '0;
            bus.busy <= 1'b0;
          end else if (counter <= CW'(1)) begin
            // Counter reaches zero on this edge; rdata is read before any commit
            state         <= RESP;
            counter       <= '0;
            bus.mem_resp  <= 1'b1;
            bus.mem_rdata <= word_rd;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.mem_resp <= 1'b0;
          bus.busy     <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.mem_resp <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

  // Line store is not reset; a reset clears state so no commit can follow
  always_ff @(posedge clk) begin
    if (state == RESP && op_write) begin
      mem[line_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Self-checking bench for pipeline_mem_responder against a line-array reference model.
module tb_pipeline_mem_responder;

  localparam int unsigned LAT = 4;
  localparam int unsigned NL  = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [127:0] model [NL];

  pipeline_mem_responder_if bus ();

  pipeline_mem_responder #(.LATENCY(LAT), .LINES(NL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) / 16) % NL;
  endfunction

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) % 16) / 2;
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] a);
    logic [127:0] l;
    l = model[line_of(a)];
    return l[word_of(a)*16 +: 16];
  endfunction

  // Issues one request, holds it until mem_resp (bounded), then drops it
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wdata, output bit got,
                     output logic [15:0] data, output int cyc);
    @(negedge clk);
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_address = addr;
    bus.mem_wdata   = wdata;
    got  = 1'b0;
    data = 16'hxxxx;
    cyc  = 0;
    for (int i = 1; i <= int'(LAT) + 6 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        got  = 1'b1;
        data = bus.mem_rdata;
        cyc  = i;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 16'h0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: resp=%b rdata=%h busy=%b required resp=0 rdata=0000 busy=0",
               bus.mem_resp, bus.mem_rdata, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    bit got; logic [15:0] d; int c;
    logic [127:0] line;
    line = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    txn(1'b0, 1'b1, 16'h0040, line, got, d, c);
    model[line_of(16'h0040)] = line;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wr_resp: resp=0 required resp=1");
    end
    txn(1'b1, 1'b0, 16'h0046, '0, got, d, c);
    total++;
    if (!got || d !== 16'h3333) begin
      bad++;
      $display("FAIL wr_then_rd: resp=%b rdata=%h required resp=1 rdata=3333", got, d);
    end
  endtask

  task automatic test_latency;
    logic exp_resp, exp_busy;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h004C;
    for (int i = 1; i <= int'(LAT) + 2; i++) begin
      @(negedge clk);
      exp_resp = (i == int'(LAT));
      exp_busy = (i >= 1 && i <= int'(LAT));
      if (i == int'(LAT)) begin
        total++;
        if (bus.mem_rdata !== model_word(16'h004C)) begin
          bad++;
          $display("FAIL latency_data: rdata=%h required %h", bus.mem_rdata, model_word(16'h004C));
        end
        bus.mem_read = 1'b0;
      end
      total++;
      if (bus.mem_resp !== exp_resp || bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL latency_cycle%0d: resp=%b busy=%b required resp=%b busy=%b",
                 i, bus.mem_resp, bus.busy, exp_resp, exp_busy);
      end
    end
  endtask

  task automatic test_abort;
    bit got; logic [15:0] d; int c;
    bit seen;
    txn(1'b0, 1'b1, 16'h0080, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, got, d, c);
    model[line_of(16'h0080)] = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    @(negedge clk);
    bus.mem_write   = 1'b1;
    bus.mem_address = 16'h0080;
    bus.mem_wdata   = {8{16'hDEAD}};
    repeat (2) @(negedge clk);
    bus.mem_write = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 3; i++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_resp: resp seen=1 required 0");
    end
    txn(1'b1, 1'b0, 16'h0080, '0, got, d, c);
    total++;
    if (!got || d !== 16'h0100) begin
      bad++;
      $display("FAIL abort_old_data: resp=%b rdata=%h required resp=1 rdata=0100", got, d);
    end
  endtask

  task automatic test_back_to_back;
    int t[2]; logic [15:0] dv[2]; int n;
    logic [15:0] a[2];
    a[0] = 16'h0042; a[1] = 16'h004E;
    n = 0;
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_address = a[0];
    for (int i = 1; i <= 3 * int'(LAT) + 6 && n < 2; i++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        t[n] = i; dv[n] = bus.mem_rdata; n++;
        bus.mem_address = a[1];
      end
    end
    bus.mem_read = 1'b0;
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL b2b_count: responses=%0d required 2", n);
    end else begin
      total++;
      if (t[1] - t[0] != int'(LAT) + 1) begin
        bad++;
        $display("FAIL b2b_spacing: spacing=%0d required %0d", t[1] - t[0], LAT + 1);
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (dv[k] !== model_word(a[k])) begin
          bad++;
          $display("FAIL b2b_data%0d: rdata=%h required %h", k, dv[k], model_word(a[k]));
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_alias_priority;
    bit got; logic [15:0] d; int c;
    logic [15:0] prior;
    txn(1'b0, 1'b1, 16'h0200, {8{16'hA5A5}} ^ 128'h1234, got, d, c);
    model[line_of(16'h0200)] = {8{16'hA5A5}} ^ 128'h1234;
    txn(1'b1, 1'b0, 16'h0000, '0, got, d, c);
    total++;
    if (!got || d !== 16'hB791) begin
      bad++;
      $display("FAIL alias: resp=%b rdata=%h required resp=1 rdata=b791", got, d);
    end
    prior = model_word(16'h0003);
    txn(1'b1, 1'b1, 16'h0003, {8{16'h5A5A}}, got, d, c);
    model[line_of(16'h0003)] = {8{16'h5A5A}};
    total++;
    if (!got || d !== prior) begin
      bad++;
      $display("FAIL prio_rbw: resp=%b rdata=%h required resp=1 rdata=%h", got, d, prior);
    end
    txn(1'b1, 1'b0, 16'h000A, '0, got, d, c);
    total++;
    if (!got || d !== 16'h5A5A) begin
      bad++;
      $display("FAIL prio_commit: resp=%b rdata=%h required resp=1 rdata=5a5a", got, d);
    end
  endtask

  task automatic test_reset_mid;
    bit got; logic [15:0] d; int c;
    bit seen;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      bus.mem_read    = (op == 0);
      bus.mem_write   = (op == 1);
      bus.mem_address = 16'h0044;
      bus.mem_wdata   = {8{16'hBEEF}};
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 16'h0000 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_op%0d: resp=%b rdata=%h busy=%b required 0/0000/0",
                 op, bus.mem_resp, bus.mem_rdata, bus.busy);
      end
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < int'(LAT) + 3; i++) begin
        @(negedge clk);
        if (bus.mem_resp === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen) begin
        bad++;
        $display("FAIL reset_no_resp_op%0d: resp seen=1 required 0", op);
      end
    end
    txn(1'b1, 1'b0, 16'h0044, '0, got, d, c);
    total++;
    if (!got || d !== model_word(16'h0044)) begin
      bad++;
      $display("FAIL reset_no_commit: resp=%b rdata=%h required %h", got, d, model_word(16'h0044));
    end
  endtask

  task automatic test_random;
    bit got; logic [15:0] d; int c;
    logic rd, wr; logic [15:0] a; logic [127:0] w; logic [15:0] exp;
    int r;
    for (int l = 0; l < int'(NL); l++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      a = 16'(l * 16);
      txn(1'b0, 1'b1, a, w, got, d, c);
      model[l] = w;
      total++;
      if (!got) begin
        bad++;
        $display("FAIL fill_line%0d: resp=0 required 1", l);
      end
    end
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      a  = 16'($urandom);
      w  = {$urandom, $urandom, $urandom, $urandom};
      exp = model_word(a);
      txn(rd, wr, a, w, got, d, c);
      if (wr) model[line_of(a)] = w;
      total++;
      if (!got || c != int'(LAT) || d !== exp) begin
        bad++;
        $display("FAIL rand%0d: rd=%b wr=%b addr=%h resp=%b cyc=%0d rdata=%h required cyc=%0d rdata=%h",
                 n, rd, wr, a, got, c, d, LAT, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    test_reset();
    test_write_read();
    test_latency();
    test_abort();
    test_back_to_back();
    test_alias_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
